// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg : FSel codes, Tnew/Tuse constants, shadow-pipeline entry
// Rev 1.0
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam logic [2:0] FSEL_E_LINK = 3'b000;
  localparam logic [2:0] FSEL_M_LINK = 3'b001;
  localparam logic [2:0] FSEL_M_ALU  = 3'b010;
  localparam logic [2:0] FSEL_W      = 3'b011;
  localparam logic [2:0] FSEL_RF     = 3'b100;

  localparam logic [1:0] TNEW_READY  = 2'd0;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       link;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_BUBBLE = '0;

  // Advance an entry by one stage: Tnew counts down and saturates at zero.
  function automatic shadow_entry_t shadow_age(input shadow_entry_t e);
    shadow_entry_t r;
    r = e;
    if (e.tnew != TNEW_READY) r.tnew = e.tnew - 2'd1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_fwd_sel : youngest-match forward select and data stall for one source
// Rev 1.0
// ----------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0]    i_src,
  input  logic [1:0]    i_tuse,
  input  shadow_entry_t i_ent_e,
  input  shadow_entry_t i_ent_m,
  input  shadow_entry_t i_ent_w,
  output logic          o_stall,
  output logic [2:0]    o_fsel
);

  logic       w_hit_e;
  logic       w_hit_m;
  logic       w_hit_w;
  logic       w_hit;
  logic [1:0] w_tnew;

  assign w_hit_e = (i_src != 5'd0) && (i_ent_e.wa == i_src);
  assign w_hit_m = (i_src != 5'd0) && (i_ent_m.wa == i_src);
  assign w_hit_w = (i_src != 5'd0) && (i_ent_w.wa == i_src);

  always_comb begin
    w_hit  = 1'b0;
    w_tnew = TNEW_READY;
    o_fsel = FSEL_RF;
    if (w_hit_e) begin
      w_hit  = 1'b1;
      w_tnew = i_ent_e.tnew;
      o_fsel = i_ent_e.link ? FSEL_E_LINK : FSEL_RF;
    end else if (w_hit_m) begin
      w_hit  = 1'b1;
      w_tnew = i_ent_m.tnew;
      if (i_ent_m.link)
        o_fsel = FSEL_M_LINK;
      else if (i_ent_m.tnew == TNEW_READY)
        o_fsel = FSEL_M_ALU;
      else
        o_fsel = FSEL_RF;
    end else if (w_hit_w) begin
      w_hit  = 1'b1;
      w_tnew = i_ent_w.tnew;
      o_fsel = FSEL_W;
    end
  end

  assign o_stall = w_hit && (i_tuse != TUSE_NONE) && (w_tnew > i_tuse);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_ctrl : shadow E/M/W write tracking, forwarding, stall and md busy.
// Optional stall counter enabled by defining HAZARD_PERF_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  wa_D,
  input  logic [1:0]  tnew_D,
  input  logic        link_D,
  input  logic        md_start_D,
  input  logic        md_div_D,
  input  logic        md_use_D,
  output logic        stall,
  output logic [2:0]  FSel1_D,
  output logic [2:0]  FSel2_D,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  import hazard_ctrl_pkg::*;

  localparam int c_md_max = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w  = $clog2(c_md_max + 1);
  localparam logic [c_cnt_w-1:0] c_mult_load = c_cnt_w'(MULT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_div_load  = c_cnt_w'(DIV_CYCLES);

  shadow_entry_t        r_ent_e;
  shadow_entry_t        r_ent_m;
  shadow_entry_t        r_ent_w;
  logic                 r_md_pend;
  logic                 r_md_div;
  logic [c_cnt_w-1:0]   r_md_cnt;
  logic                 w_stall_rs;
  logic                 w_stall_rt;
  logic                 w_md_stall;

  hazard_fwd_sel u_fwd_rs (
    .i_src   (rs_D),
    .i_tuse  (tuse_rs_D),
    .i_ent_e (r_ent_e),
    .i_ent_m (r_ent_m),
    .i_ent_w (r_ent_w),
    .o_stall (w_stall_rs),
    .o_fsel  (FSel1_D)
  );

  hazard_fwd_sel u_fwd_rt (
    .i_src   (rt_D),
    .i_tuse  (tuse_rt_D),
    .i_ent_e (r_ent_e),
    .i_ent_m (r_ent_m),
    .i_ent_w (r_ent_w),
    .o_stall (w_stall_rt),
    .o_fsel  (FSel2_D)
  );

  // A start sitting in E already counts as busy so a following HI/LO user waits.
  assign md_busy    = (r_md_cnt != '0) | r_md_pend;
  assign w_md_stall = md_use_D & md_busy;
  assign stall      = w_stall_rs | w_stall_rt | w_md_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent_e <= SHADOW_BUBBLE;
      r_ent_m <= SHADOW_BUBBLE;
      r_ent_w <= SHADOW_BUBBLE;
    end else begin
      r_ent_e <= stall ? SHADOW_BUBBLE : shadow_entry_t'{wa: wa_D, tnew: tnew_D, link: link_D};
      r_ent_m <= shadow_age(r_ent_e);
      r_ent_w <= shadow_age(r_ent_m);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_pend <= 1'b0;
      r_md_div  <= 1'b0;
      r_md_cnt  <= '0;
    end else begin
      r_md_pend <= md_start_D & ~stall;
      r_md_div  <= md_div_D;
      if (r_md_pend)
        r_md_cnt <= r_md_div ? c_div_load : c_mult_load;
      else if (r_md_cnt != '0)
        r_md_cnt <= r_md_cnt - c_cnt_w'(1);
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= 32'd0;
    else if (stall)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hazard_ctrl : scoreboard bench; reference tracks issued writes by age.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, wa_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D;
  logic        link_D, md_start_D, md_div_D, md_use_D;
  logic        stall, md_busy;
  logic [2:0]  FSel1_D, FSel2_D;
  logic [31:0] stall_cnt;

  hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wa_D(wa_D), .tnew_D(tnew_D), .link_D(link_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .stall(stall), .FSel1_D(FSel1_D), .FSel2_D(FSel2_D),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] wa;
    logic [1:0] tnew;
    logic       link, md_start, md_div, md_use;
  } ins_t;

  typedef struct {
    logic        stall;
    logic [2:0]  f1, f2;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    logic [4:0] wa;
    int         tnew;
    logic       link;
    int         te;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         hist[$];
  int          cyc = 0;
  int          md_te = -100;
  int          md_n = 0;
  int unsigned perf = 0;
  bit          model_valid = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Reference: an issued write is E/M/W purely by how many cycles ago it entered E.
  task automatic src_ref(input logic [4:0] s, input logic [1:0] tuse,
                         output logic st, output logic [2:0] fs);
    int age, rem;
    st = 1'b0;
    fs = 3'b100;
    if (s != 5'd0) begin
      for (int k = hist.size() - 1; k >= 0; k--) begin
        age = cyc - hist[k].te;
        if (age >= 0 && age <= 2 && hist[k].wa == s) begin
          rem = hist[k].tnew - age;
          if (rem < 0) rem = 0;
          if (age == 0)      fs = hist[k].link ? 3'b000 : 3'b100;
          else if (age == 1) fs = hist[k].link ? 3'b001 : (rem == 0 ? 3'b010 : 3'b100);
          else               fs = 3'b011;
          st = (tuse != 2'd3) && (rem > int'(tuse));
          break;
        end
      end
    end
  endtask

  task automatic drive_cycle(input ins_t in, input logic rst_i, output logic st);
    exp_t e;
    logic s1, s2;
    rs_D = in.rs; rt_D = in.rt; tuse_rs_D = in.tuse_rs; tuse_rt_D = in.tuse_rt;
    wa_D = in.wa; tnew_D = in.tnew; link_D = in.link;
    md_start_D = in.md_start; md_div_D = in.md_div; md_use_D = in.md_use;
    reset = rst_i;
    src_ref(in.rs, in.tuse_rs, s1, e.f1);
    src_ref(in.rt, in.tuse_rt, s2, e.f2);
    e.busy  = (cyc >= md_te) && (cyc <= md_te + md_n);
    e.stall = s1 | s2 | (in.md_use & e.busy);
`ifdef HAZARD_PERF_EN
    e.cnt = perf;
`else
    e.cnt = 32'd0;
`endif
    if (model_valid) exp_q.push_back(e);
    st = e.stall;
    @(posedge clk);
    if (rst_i) begin
      hist.delete();
      md_te = -100;
      perf = 0;
      model_valid = 1'b1;
    end else begin
      if (!st && in.wa != 5'd0) hist.push_back('{in.wa, int'(in.tnew), in.link, cyc + 1});
      if (!st && in.md_start) begin
        md_te = cyc + 1;
        md_n  = in.md_div ? DIV_N : MULT_N;
      end
      if (st) perf++;
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].te > 2) void'(hist.pop_front());
    #1;
  endtask

  // Hold the instruction in D until it is accepted, as the real pipeline would.
  task automatic issue(input ins_t in);
    logic st;
    int n;
    n = 0;
    st = 1'b1;
    while (st && n < 64) begin
      drive_cycle(in, 1'b0, st);
      n++;
    end
    if (st) begin
      failures++;
      $display("FAIL issue_timeout: stall still %0b after %0d cycles, required 0", st, n);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rs, input logic [1:0] trs,
                              input logic [4:0] rt, input logic [1:0] trt,
                              input logic [4:0] wa, input logic [1:0] tnew, input logic link,
                              input logic ms, input logic md, input logic mu);
    ins_t r;
    r = '{rs, rt, trs, trt, wa, tnew, link, ms, md, mu};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s @cyc%0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall",     32'(stall),   32'(e.stall));
      chk("FSel1_D",   32'(FSel1_D), 32'(e.f1));
      chk("FSel2_D",   32'(FSel2_D), 32'(e.f2));
      chk("md_busy",   32'(md_busy), 32'(e.busy));
      chk("stall_cnt", stall_cnt,    e.cnt);
    end
  end

  function automatic logic [4:0] pick_reg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    ins_t nop, in;
    logic st;
    nop = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    #1;
    drive_cycle(nop, 1'b1, st);
    drive_cycle(nop, 1'b1, st);
    drive_cycle(nop, 1'b0, st);

    // load-use on a branch operand
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd1, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(nop);

    // ALU result consumed in E, then from M
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_cycle(mk(5'd2, 2'd1, 5'd0, 2'd3, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, st);
    drive_cycle(mk(5'd2, 2'd1, 5'd2, 2'd0, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, st);
    issue(nop);

    // jal / jr link forwarding
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    drive_cycle(mk(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, st);
    drive_cycle(mk(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0, st);
    issue(nop);

    // div then mfhi, mult then mflo
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1));

    // register 0 never matches
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    issue(mk(5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));

    // reset in the middle of a div stall
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1));
    in = mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_cycle(in, 1'b0, st);
    drive_cycle(in, 1'b0, st);
    drive_cycle(in, 1'b0, st);
    drive_cycle(in, 1'b1, st);
    issue(in);

    // reset during a data stall
    issue(mk(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
    in = mk(5'd7, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(in, 1'b0, st);
    drive_cycle(in, 1'b1, st);
    issue(in);

    for (int i = 0; i < 700; i++) begin
      in.rs       = pick_reg();
      in.rt       = pick_reg();
      in.tuse_rs  = 2'($urandom_range(0, 3));
      in.tuse_rt  = 2'($urandom_range(0, 3));
      in.wa       = pick_reg();
      in.tnew     = 2'($urandom_range(0, 2));
      in.link     = ($urandom_range(0, 7) == 0);
      if (in.link) begin
        in.tnew = 2'd0;
        in.wa   = 5'd31;
      end
      in.md_start = ($urandom_range(0, 15) == 0);
      in.md_div   = 1'($urandom_range(0, 1));
      in.md_use   = in.md_start | ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) drive_cycle(in, 1'b1, st);
      else                             issue(in);
    end

    issue(nop);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
